// File: rtl/nibble_frame_collector.sv
// Packs a valid/ready stream of DATA_W-bit samples into NUM_LANES-lane frames.
// A fill buffer collects the next frame while the output buffer stays stable for the consumer.
module nibble_frame_collector #(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned FCNT_W    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DATA_W-1:0]             s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic                          clear_i,
    output logic [NUM_LANES*DATA_W-1:0]   frame_o,
    output logic                          frame_valid_o,
    input  logic                          frame_ready_i,
    output logic [$clog2(NUM_LANES):0]    count_o,
    output logic [FCNT_W-1:0]             frames_o
);

    localparam int unsigned CNT_W   = $clog2(NUM_LANES) + 1;
    localparam int unsigned FRAME_W = NUM_LANES * DATA_W;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FRAME_W-1:0] fill_q, fill_d, fill_wr;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               fvalid_q, fvalid_d;
    logic               ready_q, ready_d;
    logic [FCNT_W-1:0]  frames_q, frames_d;
    logic               accept, deliver;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_INIT;
            count_q  <= '0;
            fill_q   <= '0;
            frame_q  <= '0;
            fvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            fill_q   <= fill_d;
            frame_q  <= frame_d;
            fvalid_q <= fvalid_d;
            ready_q  <= ready_d;
            frames_q <= frames_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        fill_d   = fill_q;
        frame_d  = frame_q;
        fvalid_d = fvalid_q;
        frames_d = frames_q;
        fill_wr  = fill_q;
        accept   = s_valid_i & ready_q;
        deliver  = fvalid_q & frame_ready_i;

        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (count_q == CNT_W'(k)) begin
                fill_wr[k*DATA_W +: DATA_W] = s_data_i;
            end
        end

        // A delivery empties the output buffer unless a new frame is loaded below
        if (deliver) begin
            frames_d = frames_q + FCNT_W'(1);
            fvalid_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                state_d = ST_COLLECT;
                count_d = '0;
            end
            ST_COLLECT: begin
                if (clear_i) begin
                    count_d = '0;
                end else if (accept) begin
                    fill_d = fill_wr;
                    if (count_q == CNT_W'(NUM_LANES - 1)) begin
                        if (!fvalid_q || deliver) begin
                            frame_d  = fill_wr;
                            fvalid_d = 1'b1;
                            count_d  = '0;
                        end else begin
                            count_d = CNT_W'(NUM_LANES);
                            state_d = ST_PENDING;
                        end
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (clear_i) begin
                    count_d = '0;
                    state_d = ST_COLLECT;
                end else if (deliver) begin
                    frame_d  = fill_q;
                    fvalid_d = 1'b1;
                    count_d  = '0;
                    state_d  = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_INIT;
                count_d = '0;
            end
        endcase

        ready_d = (state_d == ST_COLLECT);
    end

    assign s_ready_o     = ready_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = fvalid_q;
    assign count_o       = count_q;
    assign frames_o      = frames_q;

endmodule

// File: tb/tb_nibble_frame_collector.sv
// Scoreboard bench: stimulus pushes expected frames, a monitor checks each delivery.
module tb_nibble_frame_collector;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic        clear_i = 1'b0;
    logic [63:0] frame_o;
    logic        frame_valid_o;
    logic        frame_ready_i = 1'b0;
    logic [4:0]  count_o;
    logic [7:0]  frames_o;

    int          checks = 0;
    int          failures = 0;
    int          dlv = 0;
    logic [7:0]  exp_frames = '0;
    logic [63:0] exp_q[$];

    nibble_frame_collector dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .clear_i      (clear_i),
        .frame_o      (frame_o),
        .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i),
        .count_o      (count_o),
        .frames_o     (frames_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [3:0] v);
        return {16{v}};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        int n = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        forever begin
            @(negedge clk_i);
            if (s_ready_o) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'(s_ready_o), 64'd1);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [3:0] d);
        for (int i = 0; i < n; i++) send(d);
    endtask

    task automatic pulse_ready();
        frame_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        frame_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    // Monitor: every delivery handshake must match the oldest expected frame
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_q.delete();
            exp_frames = '0;
            dlv = 0;
        end else if (frame_valid_o && frame_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("deliver_unexpected", frame_o, 64'hx);
            end else begin
                chk("deliver_frame", frame_o, exp_q.pop_front());
            end
            chk("deliver_frames_cnt", 64'(frames_o), 64'(exp_frames));
            exp_frames = exp_frames + 8'd1;
            dlv++;
        end
    end

    initial begin
        // Reset values and release latency
        @(negedge clk_i);
        chk("rst_s_ready", 64'(s_ready_o), 64'd0);
        chk("rst_fvalid", 64'(frame_valid_o), 64'd0);
        chk("rst_frame", frame_o, 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_frames", 64'(frames_o), 64'd0);
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("init_s_ready", 64'(s_ready_o), 64'd0);
        step();
        chk("collect_s_ready", 64'(s_ready_o), 64'd1);

        // Ramp 0..15 with consumer stalled
        exp_q.push_back(64'hFEDCBA9876543210);
        for (int i = 0; i < 15; i++) send(4'(i));
        @(negedge clk_i);
        chk("t1_count15", 64'(count_o), 64'd15);
        chk("t1_fvalid_before", 64'(frame_valid_o), 64'd0);
        step();
        send(4'hF);
        @(negedge clk_i);
        chk("t1_fvalid", 64'(frame_valid_o), 64'd1);
        chk("t1_frame", frame_o, 64'hFEDCBA9876543210);
        chk("t1_count", 64'(count_o), 64'd0);

        // Two frames of F: second waits in PENDING
        step();
        do_reset();
        exp_q.push_back(rep(4'hF));
        exp_q.push_back(rep(4'hF));
        send_n(32, 4'hF);
        @(negedge clk_i);
        chk("t2_count16", 64'(count_o), 64'd16);
        chk("t2_s_ready0", 64'(s_ready_o), 64'd0);
        chk("t2_fvalid", 64'(frame_valid_o), 64'd1);
        step();
        pulse_ready();
        @(negedge clk_i);
        chk("t2_frames1", 64'(frames_o), 64'd1);
        chk("t2_frame", frame_o, rep(4'hF));
        chk("t2_fvalid_hold", 64'(frame_valid_o), 64'd1);
        chk("t2_count0", 64'(count_o), 64'd0);
        chk("t2_s_ready1", 64'(s_ready_o), 64'd1);

        // Delivery coincident with last-lane accept
        step();
        exp_q.push_back(rep(4'h3));
        send_n(15, 4'h3);
        frame_ready_i = 1'b1;
        send(4'h3);
        frame_ready_i = 1'b0;
        @(negedge clk_i);
        chk("t3_fvalid", 64'(frame_valid_o), 64'd1);
        chk("t3_frame", frame_o, rep(4'h3));
        chk("t3_frames2", 64'(frames_o), 64'd2);
        chk("t3_count0", 64'(count_o), 64'd0);

        // Clear drops partial fill and the coincident sample
        step();
        pulse_ready();
        @(negedge clk_i);
        chk("t4_fvalid_drop", 64'(frame_valid_o), 64'd0);
        chk("t4_frames3", 64'(frames_o), 64'd3);
        step();
        send_n(7, 4'hA);
        clear_i   = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 4'h5;
        step();
        clear_i   = 1'b0;
        s_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t4_clear_count", 64'(count_o), 64'd0);
        chk("t4_clear_s_ready", 64'(s_ready_o), 64'd1);
        step();
        exp_q.push_back(rep(4'h1));
        send_n(15, 4'h1);
        @(negedge clk_i);
        chk("t4_count15", 64'(count_o), 64'd15);
        step();
        send(4'h1);
        @(negedge clk_i);
        chk("t4_frame", frame_o, rep(4'h1));
        chk("t4_fvalid", 64'(frame_valid_o), 64'd1);

        // Asynchronous reset mid-frame
        step();
        send_n(10, 4'h7);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t5_s_ready", 64'(s_ready_o), 64'd0);
        chk("t5_fvalid", 64'(frame_valid_o), 64'd0);
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_frames", 64'(frames_o), 64'd0);
        chk("t5_frame", frame_o, 64'd0);
        step();
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t5_init_s_ready", 64'(s_ready_o), 64'd0);
        step();
        chk("t5_s_ready1", 64'(s_ready_o), 64'd1);
        exp_q.push_back(64'h0123456789ABCDEF);
        for (int i = 0; i < 15; i++) send(4'(15 - i));
        @(negedge clk_i);
        chk("t5_no_frame", 64'(frame_valid_o), 64'd0);
        chk("t5_count15", 64'(count_o), 64'd15);
        step();
        send(4'h0);
        @(negedge clk_i);
        chk("t5_frame_new", frame_o, 64'h0123456789ABCDEF);

        // 256 deliveries: counter wraps
        step();
        frame_ready_i = 1'b1;
        for (int f = 0; f < 255; f++) begin
            exp_q.push_back(rep(4'(f)));
            send_n(16, 4'(f));
        end
        for (int n = 0; n < 100 && dlv < 256; n++) @(negedge clk_i);
        chk("t6_dlv_total", 64'(dlv), 64'd256);
        step();
        frame_ready_i = 1'b0;
        @(negedge clk_i);
        chk("t6_frames_wrap", 64'(frames_o), 64'd0);
        chk("t6_fvalid", 64'(frame_valid_o), 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
